// File: rtl/video_timing_generator.sv
// video_timing_generator: programmable raster timing with fractional pixel rate
// and frame-boundary shadow configuration.
module video_timing_generator #(
    parameter int   CW         = 11,
    parameter int   PHASE_BITS = 16,
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FRONT    = 210,
    parameter int   H_SYNC     = 20,
    parameter int   H_BACK     = 26,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 22,
    parameter int   V_SYNC     = 10,
    parameter int   V_BACK     = 13,
    parameter int   PHASE_INC  = 16499,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_cfg_load,
    input  logic [CW-1:0]         i_cfg_h_active,
    input  logic [CW-1:0]         i_cfg_h_front,
    input  logic [CW-1:0]         i_cfg_h_sync,
    input  logic [CW-1:0]         i_cfg_h_back,
    input  logic [CW-1:0]         i_cfg_v_active,
    input  logic [CW-1:0]         i_cfg_v_front,
    input  logic [CW-1:0]         i_cfg_v_sync,
    input  logic [CW-1:0]         i_cfg_v_back,
    input  logic                  i_cfg_hs_pol,
    input  logic                  i_cfg_vs_pol,
    input  logic [PHASE_BITS:0]   i_cfg_phase_inc,
    output logic                  o_pixel_ce,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_data_enable,
    output logic [CW-1:0]         o_pos_x,
    output logic [CW-1:0]         o_pos_y,
    output logic                  o_frame_start,
    output logic                  o_line_start,
    output logic                  o_cfg_pending,
    output logic                  o_cfg_error
);
    localparam int TW = CW + 2;
    localparam int PW = PHASE_BITS + 1;

    typedef struct packed {
        logic [CW-1:0] ha, hf, hs, hb, va, vf, vs, vb;
        logic          hp, vp;
        logic [PW-1:0] inc;
    } cfg_t;

    localparam cfg_t CFG_RST = '{ha: CW'(H_ACTIVE), hf: CW'(H_FRONT), hs: CW'(H_SYNC), hb: CW'(H_BACK),
                                 va: CW'(V_ACTIVE), vf: CW'(V_FRONT), vs: CW'(V_SYNC), vb: CW'(V_BACK),
                                 hp: HS_POL, vp: VS_POL, inc: PW'(PHASE_INC)};
    localparam logic [TW-1:0] T_MAX   = TW'((1 << CW) - 1);
    localparam logic [PW-1:0] INC_MAX = {1'b1, {PHASE_BITS{1'b0}}};

    cfg_t                  cfg_q, cfg_d, shd_q, shd_d, cfg_in;
    logic                  pend_q, pend_d, err_q, err_d;
    logic [PHASE_BITS-1:0] acc_q, acc_d;
    logic [CW-1:0]         nh_q, nh_d, nv_q, nv_d, x_q, x_d, y_q, y_d;
    logic                  ce_q, ce_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, ls_q, ls_d;
    logic [PW-1:0]         inc, sum;
    logic [TW-1:0]         in_h_tot, in_v_tot, h_tot, v_tot, hs_beg, vs_beg, nh_w, nv_w;
    logic                  tick, h_last, v_last, wrap, apply, in_ok, load_ok, hs_on, vs_on;

    assign cfg_in = {i_cfg_h_active, i_cfg_h_front, i_cfg_h_sync, i_cfg_h_back,
                     i_cfg_v_active, i_cfg_v_front, i_cfg_v_sync, i_cfg_v_back,
                     i_cfg_hs_pol, i_cfg_vs_pol, i_cfg_phase_inc};

    always_comb begin
        in_h_tot = TW'(cfg_in.ha) + TW'(cfg_in.hf) + TW'(cfg_in.hs) + TW'(cfg_in.hb);
        in_v_tot = TW'(cfg_in.va) + TW'(cfg_in.vf) + TW'(cfg_in.vs) + TW'(cfg_in.vb);
        in_ok    = |cfg_in.ha && |cfg_in.hs && |cfg_in.va && |cfg_in.vs && in_h_tot <= T_MAX && in_v_tot <= T_MAX;
        load_ok  = i_cfg_load && in_ok;
        err_d    = i_cfg_load && !in_ok;
        // Clamping to 2^PHASE_BITS keeps the accumulator still while carrying every clock.
        inc      = cfg_q.inc > INC_MAX ? INC_MAX : cfg_q.inc;
        sum      = {1'b0, acc_q} + inc;
        tick     = i_enable && sum[PHASE_BITS];
        acc_d    = i_enable ? sum[PHASE_BITS-1:0] : '0;
        h_tot    = TW'(cfg_q.ha) + TW'(cfg_q.hf) + TW'(cfg_q.hs) + TW'(cfg_q.hb);
        v_tot    = TW'(cfg_q.va) + TW'(cfg_q.vf) + TW'(cfg_q.vs) + TW'(cfg_q.vb);
        nh_w     = TW'(nh_q);
        nv_w     = TW'(nv_q);
        h_last   = nh_w == h_tot - TW'(1);
        v_last   = nv_w == v_tot - TW'(1);
        wrap     = tick && h_last && v_last;
        apply    = pend_q && (!i_enable || wrap);
        cfg_d    = apply ? shd_q : cfg_q;
        shd_d    = load_ok ? cfg_in : shd_q;
        pend_d   = load_ok || (pend_q && !apply);
        nh_d     = !i_enable ? '0 : !tick ? nh_q : h_last ? '0 : nh_q + 1'b1;
        nv_d     = !i_enable ? '0 : !(tick && h_last) ? nv_q : v_last ? '0 : nv_q + 1'b1;
        hs_beg   = TW'(cfg_q.ha) + TW'(cfg_q.hf);
        vs_beg   = TW'(cfg_q.va) + TW'(cfg_q.vf);
        hs_on    = nh_w >= hs_beg && nh_w < hs_beg + TW'(cfg_q.hs);
        vs_on    = nv_w >= vs_beg && nv_w < vs_beg + TW'(cfg_q.vs);
        ce_d     = tick;
        x_d      = !i_enable ? '0 : tick ? nh_q : x_q;
        y_d      = !i_enable ? '0 : tick ? nv_q : y_q;
        de_d     = i_enable && (tick ? (nh_w < TW'(cfg_q.ha) && nv_w < TW'(cfg_q.va)) : de_q);
        hs_d     = !i_enable ? !cfg_q.hp : tick ? (hs_on ? cfg_q.hp : !cfg_q.hp) : hs_q;
        vs_d     = !i_enable ? !cfg_q.vp : tick ? (vs_on ? cfg_q.vp : !cfg_q.vp) : vs_q;
        ls_d     = tick && nh_q == '0;
        fs_d     = tick && nh_q == '0 && nv_q == '0;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cfg_q  <= CFG_RST;
            shd_q  <= CFG_RST;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
            acc_q  <= '0;
            nh_q   <= '0;
            nv_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            ce_q   <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= !HS_POL;
            vs_q   <= !VS_POL;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            acc_q  <= acc_d;
            nh_q   <= nh_d;
            nv_q   <= nv_d;
            x_q    <= x_d;
            y_q    <= y_d;
            ce_q   <= ce_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign o_pixel_ce    = ce_q;
    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_data_enable = de_q;
    assign o_pos_x       = x_q;
    assign o_pos_y       = y_q;
    assign o_frame_start = fs_q;
    assign o_line_start  = ls_q;
    assign o_cfg_pending = pend_q;
    assign o_cfg_error   = err_q;
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: directed stimulus with a pixel scoreboard built from
// the raster definition; expected pixels are queued before the DUT is run.
module tb_video_timing_generator;
    typedef struct packed {
        logic [10:0] x, y;
        logic        de, hs, vs, fs, ls;
    } pix_t;

    logic        clk = 1'b0, rst_n, en, load;
    logic [10:0] c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb;
    logic [16:0] c_inc;
    logic        ce, hsync, vsync, de, fs, ls, pend, err;
    logic [10:0] px, py;

    int   total = 0, bad = 0, cyc = 0, ce_cnt = 0, last_ce = -1;
    bit   mon_on = 0, gap_chk = 0;
    pix_t exp_q[$];
    int   fs_times[$];
    int   cyc0;

    video_timing_generator dut (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_cfg_load(load),
        .i_cfg_h_active(c_ha), .i_cfg_h_front(c_hf), .i_cfg_h_sync(c_hs), .i_cfg_h_back(c_hb),
        .i_cfg_v_active(c_va), .i_cfg_v_front(c_vf), .i_cfg_v_sync(c_vs), .i_cfg_v_back(c_vb),
        .i_cfg_hs_pol(1'b0), .i_cfg_vs_pol(1'b0), .i_cfg_phase_inc(c_inc),
        .o_pixel_ce(ce), .o_hsync(hsync), .o_vsync(vsync), .o_data_enable(de),
        .o_pos_x(px), .o_pos_y(py), .o_frame_start(fs), .o_line_start(ls),
        .o_cfg_pending(pend), .o_cfg_error(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input int inc);
        c_ha = 11'(ha); c_hf = 11'(hf); c_hs = 11'(hs); c_hb = 11'(hb);
        c_va = 11'(va); c_vf = 11'(vf); c_vs = 11'(vs); c_vb = 11'(vb);
        c_inc = 17'(inc);
    endtask

    // Expected stream: first n pixels of a raster starting at (0,0), active-low syncs.
    task automatic push(input int ha, hf, hs, hb, va, vf, vs, vb, input int n);
        int ht = ha + hf + hs + hb, vt = va + vf + vs + vb;
        for (int k = 0; k < n; k++) begin
            int x = k % ht, y = (k / ht) % vt;
            pix_t p;
            p.x  = 11'(x);
            p.y  = 11'(y);
            p.de = (x < ha) && (y < va);
            p.hs = !((x >= ha + hf) && (x < ha + hf + hs));
            p.vs = !((y >= va + vf) && (y < va + vf + vs));
            p.fs = (x == 0) && (y == 0);
            p.ls = (x == 0);
            exp_q.push_back(p);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (ce) begin
                ce_cnt++;
                if (gap_chk && last_ce >= 0) begin
                    total++;
                    assert ((cyc - last_ce) inside {3, 4}) else begin
                        bad++;
                        $error("FAIL tick_gap observed=%0d expected=3or4", cyc - last_ce);
                    end
                end
                last_ce = cyc;
                if (fs) fs_times.push_back(cyc);
            end
            if (mon_on && ce) begin
                pix_t g, e;
                g = {px, py, de, hsync, vsync, fs, ls};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $error("FAIL extra_pixel observed=%h expected=none", g);
                end else begin
                    e = exp_q.pop_front();
                    assert (g === e) else begin
                        bad++;
                        $error("FAIL pixel observed=%h expected=%h (x,y,de,hs,vs,fs,ls)", g, e);
                    end
                end
            end
        end
    endtask

    task automatic pulse_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
        chk(tag, exp_q.size(), 0);
        mon_on = 0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        set_cfg(800, 210, 20, 26, 480, 22, 10, 13, 16499);
        step(2);
        chk("rst_ce", ce, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_de", de, 0);
        chk("rst_posx", px, 0);
        chk("rst_pend", pend, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        step();

        // Full-rate small raster, loaded while idle so it applies at once.
        set_cfg(4, 1, 2, 1, 2, 1, 1, 1, 65536);
        pulse_load();
        chk("idle_pend_set", pend, 1);
        step();
        chk("idle_pend_applied", pend, 0);
        push(4, 1, 2, 1, 2, 1, 1, 1, 80);
        fs_times.delete();
        cyc0 = cyc;
        mon_on = 1; en = 1'b1;
        drain("full_drain", 200);
        chk("full_rate_clocks", cyc - cyc0, 80);
        chk("full_fs_count", fs_times.size(), 2);
        if (fs_times.size() == 2) chk("full_fs_period", fs_times[1] - fs_times[0], 40);
        en = 1'b0;
        step();

        // Mid-frame load waits for the frame wrap.
        push(4, 1, 2, 1, 2, 1, 1, 1, 40);
        push(6, 1, 2, 1, 2, 1, 1, 1, 50);
        mon_on = 1; en = 1'b1;
        step(12);
        set_cfg(6, 1, 2, 1, 2, 1, 1, 1, 65536);
        pulse_load();
        chk("mid_pend_set", pend, 1);
        step(26);
        chk("mid_pend_hold", pend, 1);
        step();
        chk("mid_pend_clear", pend, 0);
        drain("boundary_drain", 100);
        en = 1'b0;
        step();

        // Validation: 2047 total accepted, later valid load overrides, bad loads rejected.
        set_cfg(2040, 1, 2, 4, 2, 1, 1, 1, 65536);
        pulse_load();
        chk("max_tot_err", err, 0);
        chk("max_tot_pend", pend, 1);
        step();
        set_cfg(6, 1, 2, 1, 2, 1, 1, 1, 65536);
        pulse_load();
        chk("good_err", err, 0);
        step();
        set_cfg(6, 1, 2, 1, 0, 1, 1, 1, 65536);
        pulse_load();
        chk("vact0_err", err, 1);
        chk("vact0_pend", pend, 0);
        step();
        chk("err_one_clock", err, 0);
        set_cfg(2041, 1, 2, 4, 2, 1, 1, 1, 65536);
        pulse_load();
        chk("htot2048_err", err, 1);
        set_cfg(800, 1000, 200, 100, 2, 1, 1, 1, 65536);
        pulse_load();
        chk("htot2100_err", err, 1);
        chk("htot2100_pend", pend, 0);
        step();
        push(6, 1, 2, 1, 2, 1, 1, 1, 50);
        mon_on = 1; en = 1'b1;
        drain("reject_drain", 100);
        en = 1'b0;
        step();

        // Enable drop mid-frame restarts at (0,0).
        push(6, 1, 2, 1, 2, 1, 1, 1, 13);
        mon_on = 1; en = 1'b1;
        step(13);
        chk("pre_dis_drain", exp_q.size(), 0);
        en = 1'b0;
        step();
        chk("dis_de", de, 0);
        chk("dis_hsync", hsync, 1);
        chk("dis_vsync", vsync, 1);
        chk("dis_posy", py, 0);
        step(4);
        chk("dis_ce", ce, 0);
        push(6, 1, 2, 1, 2, 1, 1, 1, 50);
        en = 1'b1;
        drain("reenable_drain", 100);
        en = 1'b0;
        step();

        // Asynchronous reset in mid-line.
        push(6, 1, 2, 1, 2, 1, 1, 1, 4);
        mon_on = 1; en = 1'b1;
        step(4);
        chk("pre_rst_posx", px, 3);
        mon_on = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_posx", px, 0);
        chk("async_ce", ce, 0);
        chk("async_hsync", hsync, 1);
        chk("async_vsync", vsync, 1);
        chk("async_ls", ls, 0);
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();

        // Parameter timing at fractional rate: 16384*16499/65536 = 4124.75 ticks.
        push(800, 210, 20, 26, 480, 22, 10, 13, 4124);
        ce_cnt = 0; last_ce = -1; gap_chk = 1;
        mon_on = 1; en = 1'b1;
        step(16384);
        gap_chk = 0; mon_on = 0;
        chk("frac_ticks", ce_cnt, 4124);
        chk("frac_drain", exp_q.size(), 0);
        exp_q.delete();
        en = 1'b0;
        step();

        // Zero increment never ticks.
        set_cfg(4, 1, 2, 1, 2, 1, 1, 1, 0);
        pulse_load();
        step();
        ce_cnt = 0;
        en = 1'b1;
        step(100);
        chk("inc0_ticks", ce_cnt, 0);
        chk("inc0_posx", px, 0);
        chk("inc0_de", de, 0);
        chk("inc0_hsync", hsync, 1);
        en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Programmable raster timing generator; successor to the fixed 800x480 LCD scan-out counter.
- Generates pixel-clock enable, hsync/vsync, data enable, scan position and frame/line strobes for LCD and VGA panels from one system clock.
- Pixel rate comes from a fractional phase accumulator, so any pixel frequency below the system clock is possible.
- Timing is runtime-configurable through shadow registers that take effect only at frame boundaries.

Parameters:
- CW, 11, width of position and timing-field ports.
- PHASE_BITS, 16, phase accumulator width.
- H_ACTIVE, 800, reset value of horizontal active pixels.
- H_FRONT, 210, reset value of horizontal front porch.
- H_SYNC, 20, reset value of hsync width.
- H_BACK, 26, reset value of horizontal back porch (H total 1056).
- V_ACTIVE, 480, reset value of vertical active lines.
- V_FRONT, 22, reset value of vertical front porch.
- V_SYNC, 10, reset value of vsync width.
- V_BACK, 13, reset value of vertical back porch (V total 525).
- PHASE_INC, 16499, reset phase increment (25.175 MHz from 100 MHz).
- HS_POL, 0, reset hsync active level.
- VS_POL, 0, reset vsync active level.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  run; when low, timing is held idle.
- i_cfg_load  in  1  one-cycle strobe that captures all i_cfg_* inputs into the pending shadow.
- i_cfg_h_active, i_cfg_h_front, i_cfg_h_sync, i_cfg_h_back  in  CW each  horizontal timing.
- i_cfg_v_active, i_cfg_v_front, i_cfg_v_sync, i_cfg_v_back  in  CW each  vertical timing.
- i_cfg_hs_pol, i_cfg_vs_pol  in  1 each  sync active levels.
- i_cfg_phase_inc  in  PHASE_BITS+1  phase increment per clock.
- o_pixel_ce  out  1  one-cycle strobe; all other timing outputs present a new pixel in this cycle.
- o_hsync, o_vsync  out  1  sync outputs at the configured polarity.
- o_data_enable  out  1  high inside the active area.
- o_pos_x, o_pos_y  out  CW  raw raster counters (0..total-1).
- o_frame_start  out  1  pixel (0,0), qualified by o_pixel_ce.
- o_line_start  out  1  x==0, qualified by o_pixel_ce.
- o_cfg_pending  out  1  a validated config is waiting for the frame boundary.
- o_cfg_error  out  1  one-cycle pulse when a loaded config is rejected.

Behaviour:
- Reset (i_reset low, async):
  - Accumulator, counters and all outputs go to 0, except o_hsync=~HS_POL and o_vsync=~VS_POL.
  - Active config is set from the parameters; the pending shadow is cleared.
- Raster layout per line: active [0,h_active), front porch, sync, back porch. h_total = sum of the four fields. Vertical is identical in lines.
- Accumulator: acc <= acc + inc every clock while enabled.
  - tick = carry out of bit PHASE_BITS-1.
  - inc >= 2^PHASE_BITS is clamped to 2^PHASE_BITS, giving a tick every clock.
  - inc = 0 never ticks; outputs hold.
- Internal next-pixel counters (nh, nv) start at (0,0).
- On each tick:
  - All outputs are registered from the decode of (nh, nv): pos=(nh,nv); DE = nh<h_active && nv<v_active; hsync active when nh in [h_active+h_front, h_active+h_front+h_sync); vsync likewise on nv (line-granular); line_start = nh==0; frame_start = nh==0 && nv==0.
  - In the same edge, nh advances and wraps at h_total-1, incrementing nv; nv wraps at v_total-1.
- o_pixel_ce equals tick, delayed by that same register stage. Pulses last exactly one clock. Other outputs are stable between ticks.
- Config validation happens on i_cfg_load:
  - Rejected (o_cfg_error pulse next cycle, pending unchanged) if any active or sync field is 0, or if h_total or v_total exceeds 2^CW-1. Sums are computed at CW+2 bits.
  - Otherwise the shadow is captured and o_cfg_pending=1.
  - A second load while pending overwrites the shadow (last valid wins).
- Applying config:
  - Happens on the tick that wraps nv to 0 (end of the last line's last pixel). The next pixel, (0,0), already uses the new timing. The accumulator is not reset. o_cfg_pending clears in the same edge.
  - i_cfg_load and a boundary tick in the same cycle: the old pending config is applied and the new config becomes pending.
- i_enable low:
  - Accumulator, nh and nv clear. Outputs return to their reset values, with sync at the inactive level of the active config.
  - A pending config is applied immediately.
  - After i_enable rises, the first tick presents (0,0) with frame_start=1.
- Timing decode and output stage live within a single clock domain; no CDC inside the block.

Test Plan:
- Full-rate small raster: config h=4/1/2/1, v=2/1/1/1, inc=65536 -> o_pixel_ce every clock. x sequence is 0..7 repeating. DE high for x<4 and y<2. hsync active for x=5,6. vsync active on y=3. frame_start once per 40 clocks.
- Fractional rate: default config, inc=16499 -> exactly 16499 ticks per 65536 clocks (±1). Tick spacing is 3 or 4 clocks. One line = 1056 ticks.
- Config at frame boundary: load h_active=6 mid-frame -> o_cfg_pending=1 until the wrap tick. The old x sequence (total 8) completes. The next frame has total 10 and DE for x<6.
- Rejection: load with v_active=0, or h fields summing to 2100 with CW=11 -> o_cfg_error pulses 1 clock. pending=0. Timing is unchanged.
- Reset mid-line: drop i_reset at x=3 -> outputs go to reset values asynchronously. After release and the first tick, pos=(0,0) and frame_start=1 with the parameter timing.
- Enable toggle and edge cases: drop i_enable for 5 clocks -> DE=0 and sync inactive; after re-enable, the first tick is (0,0). inc=0 -> o_pixel_ce never asserts and outputs hold.
